// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, error codes, frame size.
// Used by the host transmitter and the keyboard scan-code receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
    localparam logic [1:0] PS2_ERR_NOACK   = 2'b01;
    localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b10;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic       start;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    modport master (output start, data, input busy, done, error, err_code);
    modport slave  (input start, data, output busy, done, error, err_code);
endinterface

// File: rtl/ps2_sync_edge.sv
// PS/2 pin synchronizer and clock falling-edge detector.
// Optional macro PS2_TX_GLITCH_FILTER_EN: only accept a falling edge after
// the synced clock has stayed low 4 cycles following a high level.
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_clk_s,
    output logic o_dat_s,
    output logic o_clk_fall
);
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;

    // Two-flop synchronizers; reset to the idle (high) bus level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], i_ps2_clk};
            dat_sync <= {dat_sync[0], i_ps2_dat};
        end
    end

    assign o_clk_s = clk_sync[1];
    assign o_dat_s = dat_sync[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [1:0] low_cnt;
    logic       armed;

    // Count low cycles; one edge per high-to-low excursion of 4+ cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            low_cnt <= 2'd0;
            armed   <= 1'b1;
        end else if (o_clk_s) begin
            low_cnt <= 2'd0;
            armed   <= 1'b1;
        end else begin
            if (low_cnt != 2'd3) low_cnt <= low_cnt + 2'd1;
            if (o_clk_fall)      armed   <= 1'b0;
        end
    end

    assign o_clk_fall = armed && !o_clk_s && (low_cnt == 2'd3);
`else
    logic clk_prev;

    // Previous synced clock level for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) clk_prev <= 1'b1;
        else       clk_prev <= o_clk_s;
    end

    assign o_clk_fall = clk_prev && !o_clk_s;
`endif

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocks out one command
// byte on device clock edges and checks the device ACK. Pins are driven
// open-drain via output enables. Optional macro PS2_TX_GLITCH_FILTER_EN is
// handled inside ps2_sync_edge.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int SETUP_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ps2_host_tx_if.slave cmd,
    input  logic         i_ps2_clk,
    input  logic         i_ps2_dat,
    output logic         o_ps2_clk_oe,
    output logic         o_ps2_dat_oe
);
    localparam int MAX_A = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int MAX_B = (MAX_A > SETUP_CYCLES) ? MAX_A : SETUP_CYCLES;
    localparam int CW    = $clog2(MAX_B + 1);

    ps2_tx_state_e             state, state_nxt;
    logic [CW-1:0]             cnt;
    logic [PS2_FRAME_BITS-2:0] frame;
    logic [3:0]                bit_cnt;
    logic                      dat_drv;
    logic                      done_q, error_q;
    logic [1:0]                err_code_q;
    logic                      clk_s, dat_s, clk_fall;
    logic                      inh_last, setup_last, tmo_hit, last_edge, timeout;

    ps2_sync_edge u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_dat  (i_ps2_dat),
        .o_clk_s    (clk_s),
        .o_dat_s    (dat_s),
        .o_clk_fall (clk_fall)
    );

    assign inh_last   = (cnt == CW'(INHIBIT_CYCLES - 1));
    assign setup_last = (cnt == CW'(SETUP_CYCLES - 1));
    assign tmo_hit    = (cnt >= CW'(TIMEOUT_CYCLES - 1));
    // edge 10 (stop bit) finishes the SEND phase
    assign last_edge  = clk_fall && (bit_cnt == 4'(PS2_FRAME_BITS - 2));

    // Timeout qualifier: a completion or no-ACK event in the same cycle wins
    always_comb begin
        timeout = 1'b0;
        case (state)
            ST_SEND:      timeout = tmo_hit && !last_edge;
            ST_ACK:       timeout = tmo_hit && !clk_fall;
            ST_WAIT_IDLE: timeout = tmo_hit && !(clk_s && dat_s);
            default:      timeout = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (cmd.start) state_nxt = ST_INHIBIT;
            ST_INHIBIT:   if (inh_last) state_nxt = ST_REQ;
            ST_REQ:       if (setup_last) state_nxt = ST_SEND;
            ST_SEND: begin
                if (last_edge)    state_nxt = ST_ACK;
                else if (timeout) state_nxt = ST_IDLE;
            end
            ST_ACK: begin
                if (clk_fall)     state_nxt = dat_s ? ST_IDLE : ST_WAIT_IDLE;
                else if (timeout) state_nxt = ST_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (clk_s && dat_s) state_nxt = ST_IDLE;
                else if (timeout)   state_nxt = ST_IDLE;
            end
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Line enables and busy derived from state
    always_comb begin
        cmd.busy     = (state != ST_IDLE);
        o_ps2_clk_oe = (state == ST_INHIBIT) || (state == ST_REQ);
        o_ps2_dat_oe = (state == ST_REQ) || ((state == ST_SEND) && dat_drv);
    end

    assign cmd.done     = done_q;
    assign cmd.error    = error_q;
    assign cmd.err_code = err_code_q;

    // Datapath: phase counter, frame shifter, result pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt        <= '0;
            frame      <= '0;
            bit_cnt    <= 4'd0;
            dat_drv    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= PS2_ERR_NONE;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd.start) begin
                        frame      <= {1'b1, ps2_odd_parity(cmd.data), cmd.data};
                        cnt        <= '0;
                        bit_cnt    <= 4'd0;
                        err_code_q <= PS2_ERR_NONE;
                    end
                end
                ST_INHIBIT: cnt <= inh_last ? '0 : cnt + CW'(1);
                ST_REQ: begin
                    // start bit stays driven until the first device edge
                    cnt     <= setup_last ? '0 : cnt + CW'(1);
                    dat_drv <= 1'b1;
                end
                ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                    cnt <= cnt + CW'(1);
                    if ((state == ST_SEND) && clk_fall) begin
                        dat_drv <= ~frame[0];
                        frame   <= frame >> 1;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    if ((state == ST_ACK) && clk_fall && dat_s) begin
                        error_q    <= 1'b1;
                        err_code_q <= PS2_ERR_NOACK;
                    end
                    if ((state == ST_WAIT_IDLE) && clk_s && dat_s) done_q <= 1'b1;
                    if (timeout) begin
                        error_q    <= 1'b1;
                        err_code_q <= PS2_ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 6000;
    localparam int SET = 250;
    localparam int TMO = 1000;
    localparam int H   = 20;
`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if ifc();
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic clk_oe, dat_oe;
    logic pin_clk, pin_dat;
    assign pin_clk = dev_clk & ~clk_oe;
    assign pin_dat = dev_dat & ~dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .cmd          (ifc.slave),
        .i_ps2_clk    (pin_clk),
        .i_ps2_dat    (pin_dat),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_dat_oe (dat_oe)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_rise = 0, t_send = 0, t_err = 0, clk_len = 0, dat_off = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_bad = 0;
    logic clk_oe_q = 1'b0, dat_oe_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line timing and result-pulse monitor
    always @(negedge clk) begin
        clk_oe_q <= clk_oe;
        dat_oe_q <= dat_oe;
        if (clk_oe && !clk_oe_q) t_rise <= cyc;
        if (!clk_oe && clk_oe_q) begin
            clk_len <= cyc - t_rise;
            t_send  <= cyc;
        end
        if (dat_oe && !dat_oe_q && clk_oe) dat_off <= cyc - t_rise;
        if (ifc.done) done_cnt <= done_cnt + 1;
        if (ifc.error) begin
            err_cnt <= err_cnt + 1;
            t_err   <= cyc;
        end
        if (ifc.done && ifc.error) both_cnt <= both_cnt + 1;
        if ((ifc.done || ifc.error) && ifc.busy) busy_bad <= busy_bad + 1;
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] d);
        @(posedge clk); #1;
        ifc.start = 1'b1;
        ifc.data  = d;
        @(posedge clk); #1;
        ifc.start = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        int g = 0;
        while (!(ifc.busy === 1'b1 && clk_oe === 1'b0) && g < 8000) begin
            cyc_wait(1);
            g++;
        end
        ok = (g < 8000);
    endtask

    // Device side: nedges clock pulses, samples released data level before next edge
    task automatic dev_frame(input logic ack_lvl, input int nedges,
                             output logic [9:0] got, output bit ok);
        got = '0;
        wait_send(ok);
        if (!ok) return;
        cyc_wait(5);
        for (int k = 1; k <= nedges; k++) begin
            dev_clk = 1'b0;
            if (k == 11) dev_dat = ack_lvl;
            cyc_wait(H);
            dev_clk = 1'b1;
            cyc_wait(H - 1);
            if (k <= 10) got[k-1] = pin_dat;
            cyc_wait(1);
        end
        dev_dat = 1'b1;
    endtask

    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        cyc_wait(3);
        rst = 1'b0;
        cyc_wait(1);
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
        total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", ifc.done); end
        total++; if (ifc.error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", ifc.error); end
        total++; if (ifc.err_code !== 2'b00) begin bad++; $display("FAIL reset_code: got %b want 00", ifc.err_code); end
        total++; if ({clk_oe, dat_oe} !== 2'b00) begin bad++; $display("FAIL reset_oe: got %b want 00", {clk_oe, dat_oe}); end
    endtask

    task automatic test_send(input logic [7:0] d);
        logic [9:0] got, exp;
        bit ok;
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt;
        exp = ref_frame(d);
        send_cmd(d);
        total++; if ({ifc.busy, clk_oe} !== 2'b11) begin bad++; $display("FAIL accept_%h: busy/clk_oe %b want 11", d, {ifc.busy, clk_oe}); end
        dev_frame(1'b0, 11, got, ok);
        total++; if (!ok) begin bad++; $display("FAIL send_entry_%h: no clock release", d); end
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin cyc_wait(1); n++; end
        cyc_wait(1);
        total++; if (got !== exp) begin bad++; $display("FAIL bits_%h: got %b want %b", d, got, exp); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL done_%h: got %0d pulses want 1", d, done_cnt - d0); end
        total++; if (err_cnt != e0) begin bad++; $display("FAIL noerr_%h: got %0d errors want 0", d, err_cnt - e0); end
        total++; if (ifc.err_code !== 2'b00) begin bad++; $display("FAIL code_%h: got %b want 00", d, ifc.err_code); end
        total++; if (clk_len !== INH + SET) begin bad++; $display("FAIL clk_oe_len_%h: got %0d want %0d", d, clk_len, INH + SET); end
        total++; if (dat_off !== INH) begin bad++; $display("FAIL dat_oe_off_%h: got %0d want %0d", d, dat_off, INH); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL idle_after_%h: busy %b want 0", d, ifc.busy); end
    endtask

    task automatic test_noack();
        logic [9:0] got;
        bit ok;
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'($urandom));
        dev_frame(1'b1, 11, got, ok);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin cyc_wait(1); n++; end
        cyc_wait(2);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL noack_err: got %0d pulses want 1", err_cnt - e0); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL noack_done: got %0d want 0", done_cnt - d0); end
        total++; if (ifc.err_code !== 2'b01) begin bad++; $display("FAIL noack_code: got %b want 01", ifc.err_code); end
        total++; if ({clk_oe, dat_oe} !== 2'b00) begin bad++; $display("FAIL noack_oe: got %b want 00", {clk_oe, dat_oe}); end
    endtask

    task automatic test_timeout();
        bit ok;
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'($urandom));
        wait_send(ok);
        n = 0;
        while (err_cnt == e0 && n < 2 * TMO) begin cyc_wait(1); n++; end
        cyc_wait(1);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL tmo_err: got %0d pulses want 1", err_cnt - e0); end
        total++; if (ifc.err_code !== 2'b10) begin bad++; $display("FAIL tmo_code: got %b want 10", ifc.err_code); end
        total++; if (t_err - t_send !== TMO) begin bad++; $display("FAIL tmo_time: got %0d want %0d", t_err - t_send, TMO); end
        total++; if ({clk_oe, dat_oe, ifc.busy} !== 3'b000) begin bad++; $display("FAIL tmo_idle: got %b want 000", {clk_oe, dat_oe, ifc.busy}); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL tmo_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_busy_reset();
        logic [7:0] d;
        logic [9:0] got;
        bit ok;
        int d0, e0;
        d = 8'($urandom) & 8'hF7;
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(d);
        cyc_wait(10);
        ifc.start = 1'b1; ifc.data = 8'hFF;
        cyc_wait(1);
        ifc.start = 1'b0; ifc.data = 8'h00;
        dev_frame(1'b0, 4, got, ok);
        total++; if (got[3:0] !== d[3:0]) begin bad++; $display("FAIL busy_ignore: got %b want %b", got[3:0], d[3:0]); end
        cyc_wait(5);
        rst = 1'b1;
        cyc_wait(1);
        total++; if ({clk_oe, dat_oe, ifc.busy} !== 3'b000) begin bad++; $display("FAIL rst_release: got %b want 000", {clk_oe, dat_oe, ifc.busy}); end
        rst = 1'b0;
        cyc_wait(200);
        total++; if (done_cnt != d0 || err_cnt != e0) begin bad++; $display("FAIL rst_pulses: done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rst_noqueue: busy %b want 0", ifc.busy); end
        test_send(8'hF4);
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        bit ok;
        d = 8'($urandom) | 8'h03;
        send_cmd(d);
        wait_send(ok);
        cyc_wait(10);
        dev_clk = 1'b0; cyc_wait(2); dev_clk = 1'b1; cyc_wait(12);
        total++; if (dat_oe !== (FILT ? 1'b1 : ~d[0])) begin bad++; $display("FAIL glitch1: dat_oe %b want %b", dat_oe, FILT ? 1'b1 : ~d[0]); end
        dev_clk = 1'b0; cyc_wait(2); dev_clk = 1'b1; cyc_wait(12);
        total++; if (dat_oe !== (FILT ? 1'b1 : ~d[1])) begin bad++; $display("FAIL glitch2: dat_oe %b want %b", dat_oe, FILT ? 1'b1 : ~d[1]); end
        rst = 1'b1;
        cyc_wait(2);
        rst = 1'b0;
        cyc_wait(5);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.data  = 8'h00;
        test_reset();
        test_send(8'hED);
        test_send(8'h01);
        test_send(8'($urandom));
        test_noack();
        test_timeout();
        test_busy_reset();
        test_glitch();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL done_and_error: got %0d overlaps want 0", both_cnt); end
        total++; if (busy_bad != 0) begin bad++; $display("FAIL busy_at_pulse: got %0d want 0", busy_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
